sprites_aga: RTL

- Parametrised successor of the OCS/ECS sprite serialiser in Denise. Holds NSPR hardware sprites, each with a data latch up to DATW bits wide.
- Supports runtime-selectable sprite width (16/32/64) and sprite pixel resolution (lores/hires/shres). Horizontal position has super-hires (35 ns) granularity.
- Feeds the colour/priority logic with nsprite valid bits and a 4-bit sprite colour index.

---
 rtl/sprites_aga.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sprites_aga.sv
// rtl/sprites_aga.sv - AGA sprite serialiser: NSPR sprites, 16/32/64-bit width, lores/hires/shres pixels
module sprites_aga #(
  parameter int         NSPR    = 8,
  parameter int         DATW    = 64,
  parameter logic [8:0] SPRBASE = 9'h140
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [8:1]      reg_address_in,
  input  logic [DATW-1:0] data_in,
  input  logic [10:0]     hpos,
  input  logic [1:0]      sprw,
  input  logic [1:0]      spres,
  input  logic            sprena,
  output logic [NSPR-1:0] nsprite,
  output logic [3:0]      sprdata
);

  localparam int NPAIR = NSPR / 2;
  localparam int W32   = (DATW < 32) ? DATW : 32;

  // per-sprite register write strobes
  logic [NSPR-1:0] pos_wr, ctl_wr, data_wr, datb_wr;

  // left-align shift for the selected width, and pixel period minus one
  logic [6:0] shamt;
  logic [1:0] divm1;

  logic [NSPR-1:0]  armed_q, armed_d;
  logic [NSPR-1:0]  load_q, load_d;
  logic [NPAIR-1:0] attach_q, attach_d;
  logic [10:0]      hstart_q [NSPR];
  logic [10:0]      hstart_d [NSPR];
  logic [DATW-1:0]  datla_q  [NSPR];
  logic [DATW-1:0]  datla_d  [NSPR];
  logic [DATW-1:0]  datlb_q  [NSPR];
  logic [DATW-1:0]  datlb_d  [NSPR];
  logic [DATW-1:0]  shifta_q [NSPR];
  logic [DATW-1:0]  shifta_d [NSPR];
  logic [DATW-1:0]  shiftb_q [NSPR];
  logic [DATW-1:0]  shiftb_d [NSPR];
  logic [1:0]       pre_q    [NSPR];
  logic [1:0]       pre_d    [NSPR];
  logic [1:0]       div_q    [NSPR];
  logic [1:0]       div_d    [NSPR];
  logic [1:0]       pix      [NSPR];

  // address decode: sprites at or above NSPR never get a strobe
  always_comb begin
    pos_wr  = '0;
    ctl_wr  = '0;
    data_wr = '0;
    datb_wr = '0;
    for (int n = 0; n < NSPR; n++) begin
      if (reg_address_in[8:6] == SPRBASE[8:6] && reg_address_in[5:3] == 3'(n)) begin
        case (reg_address_in[2:1])
          2'd0:    pos_wr[n]  = 1'b1;
          2'd1:    ctl_wr[n]  = 1'b1;
          2'd2:    data_wr[n] = 1'b1;
          default: datb_wr[n] = 1'b1;
        endcase
      end
    end
  end

  // width and resolution selection shared by all sprites
  always_comb begin
    case (sprw)
      2'b00:   shamt = 7'(DATW - 16);
      2'b11:   shamt = 7'd0;
      default: shamt = 7'(DATW - W32);
    endcase
    case (spres)
      2'b10:   divm1 = 2'd1;
      2'b11:   divm1 = 2'd0;
      default: divm1 = 2'd3;
    endcase
  end

  // next-state: register writes, hstart match, shift register load and shifting
  always_comb begin
    armed_d  = armed_q;
    attach_d = attach_q;
    for (int p = 0; p < NPAIR; p++) begin
      if (ctl_wr[2*p+1]) attach_d[p] = data_in[7];
    end
    for (int n = 0; n < NSPR; n++) begin
      hstart_d[n] = hstart_q[n];
      datla_d[n]  = datla_q[n];
      datlb_d[n]  = datlb_q[n];
      shifta_d[n] = shifta_q[n];
      shiftb_d[n] = shiftb_q[n];
      pre_d[n]    = pre_q[n];
      div_d[n]    = div_q[n];
      if (pos_wr[n]) hstart_d[n][10:3] = data_in[7:0];
      if (ctl_wr[n]) begin
        hstart_d[n][2]   = data_in[0];
        hstart_d[n][1:0] = data_in[4:3];
        armed_d[n]       = 1'b0;
      end
      if (data_wr[n]) begin
        datla_d[n] = data_in;
        armed_d[n] = 1'b1;
      end
      if (datb_wr[n]) datlb_d[n] = data_in;
      // a CTL write in the match cycle suppresses the load
      load_d[n] = armed_q[n] & (hpos == hstart_q[n]) & ~ctl_wr[n];
      // load_q is the delayed match; the shift registers take the latches as
      // they stand before this cycle's writes, so the first pixel shows two
      // clocks after the match
      if (load_q[n]) begin
        shifta_d[n] = datla_q[n] << shamt;
        shiftb_d[n] = datlb_q[n] << shamt;
        pre_d[n]    = 2'd0;
        div_d[n]    = divm1;
      end else if (pre_q[n] == div_q[n]) begin
        shifta_d[n] = shifta_q[n] << 1;
        shiftb_d[n] = shiftb_q[n] << 1;
        pre_d[n]    = 2'd0;
        div_d[n]    = divm1;
      end else begin
        pre_d[n] = pre_q[n] + 2'd1;
      end
    end
  end

  // state registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q  <= '0;
      load_q   <= '0;
      attach_q <= '0;
      for (int n = 0; n < NSPR; n++) begin
        hstart_q[n] <= '0;
        datla_q[n]  <= '0;
        datlb_q[n]  <= '0;
        shifta_q[n] <= '0;
        shiftb_q[n] <= '0;
        pre_q[n]    <= '0;
        div_q[n]    <= '0;
      end
    end else begin
      armed_q  <= armed_d;
      load_q   <= load_d;
      attach_q <= attach_d;
      for (int n = 0; n < NSPR; n++) begin
        hstart_q[n] <= hstart_d[n];
        datla_q[n]  <= datla_d[n];
        datlb_q[n]  <= datlb_d[n];
        shifta_q[n] <= shifta_d[n];
        shiftb_q[n] <= shiftb_d[n];
        pre_q[n]    <= pre_d[n];
        div_q[n]    <= div_d[n];
      end
    end
  end

  // per-sprite pixel and pair priority: lowest visible pair wins
  always_comb begin
    sprdata = 4'd0;
    for (int n = 0; n < NSPR; n++) begin
      pix[n]     = {shiftb_q[n][DATW-1], shifta_q[n][DATW-1]};
      nsprite[n] = sprena & (pix[n] != 2'd0);
    end
    for (int p = NPAIR - 1; p >= 0; p--) begin
      if (nsprite[2*p] | nsprite[2*p+1]) begin
        if (attach_q[p])         sprdata = {pix[2*p+1], pix[2*p]};
        else if (nsprite[2*p])   sprdata = {2'(p), pix[2*p]};
        else                     sprdata = {2'(p), pix[2*p+1]};
      end
    end
  end

endmodule
